// File: rtl/np_fm_buffer_write_ctrl_pkg.sv
// Shared network parameters and write-controller state encoding for the FFN feature-map buffers.
package np_fm_buffer_write_ctrl_pkg;

  localparam int unsigned NP_ADDR_MAX        = 121;
  localparam int unsigned NP_NUM_KERNELS     = 8;
  localparam int unsigned NP_ADDR_WIDTH      = 7;
  localparam int unsigned NP_SEL_WIDTH       = 3;
  localparam int unsigned NP_DATA_WIDTH      = 16;
  localparam int unsigned NP_FRAME_CNT_WIDTH = 8;

  // Encoding is shared with the read controller's testbench, so values are pinned.
  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_LAUNCH = 2'd2,
    ST_WAIT   = 2'd3
  } wr_state_e;

endpackage

// File: rtl/np_bank_addr_counter.sv
// Word-address / bank-select counter: addr wraps at ADDR_MAX and bumps sel; last marks the frame's final slot.
module np_bank_addr_counter
  import np_fm_buffer_write_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_MAX    = NP_ADDR_MAX,
  parameter int unsigned NUM_KERNELS = NP_NUM_KERNELS,
  parameter int unsigned ADDR_WIDTH  = NP_ADDR_WIDTH,
  parameter int unsigned SEL_WIDTH   = NP_SEL_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic                  last
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(ADDR_MAX - 1);
  localparam logic [SEL_WIDTH-1:0]  SEL_LAST  = SEL_WIDTH'(NUM_KERNELS - 1);

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic                  addr_wrap;

  assign addr_wrap = (addr_q == ADDR_LAST);
  assign last      = addr_wrap && (sel_q == SEL_LAST);
  assign addr      = addr_q;
  assign sel       = sel_q;

  always_comb begin
    addr_d = addr_q;
    sel_d  = sel_q;
    if (clear) begin
      addr_d = '0;
      sel_d  = '0;
    end else if (inc) begin
      if (addr_wrap) begin
        addr_d = '0;
        sel_d  = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      sel_q  <= '0;
    end else begin
      addr_q <= addr_d;
      sel_q  <= sel_d;
    end
  end

endmodule

// File: rtl/np_fm_buffer_write_ctrl.sv
// FFN feature-map RAM write controller: fills all banks from a valid/ready stream, launches the
// matrix-multiply reader, and blocks new input until the reader hands the frame back.
module np_fm_buffer_write_ctrl
  import np_fm_buffer_write_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_MAX    = NP_ADDR_MAX,
  parameter int unsigned NUM_KERNELS = NP_NUM_KERNELS,
  parameter int unsigned ADDR_WIDTH  = NP_ADDR_WIDTH,
  parameter int unsigned SEL_WIDTH   = NP_SEL_WIDTH,
  parameter int unsigned DATA_WIDTH  = NP_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [SEL_WIDTH-1:0]  wr_sel,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  mult_start,
  input  logic                  product_rdy,
  output logic [7:0]            frame_count,
  output logic                  err_rdy
);

  wr_state_e             state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [SEL_WIDTH-1:0]  wr_sel_q, wr_sel_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  mult_start_q, mult_start_d;
  logic [7:0]            frame_count_q, frame_count_d;
  logic                  err_rdy_q, err_rdy_d;

  logic                  transfer;
  logic                  cnt_inc;
  logic [ADDR_WIDTH-1:0] cnt_addr;
  logic [SEL_WIDTH-1:0]  cnt_sel;
  logic                  cnt_last;

  assign transfer = in_valid & in_ready_q;

  np_bank_addr_counter #(
    .ADDR_MAX   (ADDR_MAX),
    .NUM_KERNELS(NUM_KERNELS),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SEL_WIDTH  (SEL_WIDTH)
  ) u_addr_counter (
    .clock(clock),
    .reset(reset),
    .clear(flush),
    .inc  (cnt_inc),
    .addr (cnt_addr),
    .sel  (cnt_sel),
    .last (cnt_last)
  );

  always_comb begin
    state_d       = state_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_sel_d      = wr_sel_q;
    wr_data_d     = wr_data_q;
    mult_start_d  = 1'b0;
    frame_count_d = frame_count_q;
    err_rdy_d     = err_rdy_q | (product_rdy & (state_q != ST_WAIT));
    cnt_inc       = 1'b0;
    if (flush) begin
      state_d = ST_FILL;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (transfer) begin
            cnt_inc   = 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_addr;
            wr_sel_d  = cnt_sel;
            wr_data_d = in_data;
            if (cnt_last) state_d = ST_DRAIN;
          end
        end
        // Outputs are registered, so the launch pulse and count bump are set up while leaving DRAIN.
        ST_DRAIN: begin
          state_d       = ST_LAUNCH;
          mult_start_d  = 1'b1;
          frame_count_d = frame_count_q + 8'd1;
        end
        ST_LAUNCH: state_d = ST_WAIT;
        ST_WAIT:   if (product_rdy) state_d = ST_FILL;
        default:   state_d = ST_FILL;
      endcase
    end
    in_ready_d = (state_d == ST_FILL);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_FILL;
      in_ready_q    <= 1'b1;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_sel_q      <= '0;
      wr_data_q     <= '0;
      mult_start_q  <= 1'b0;
      frame_count_q <= '0;
      err_rdy_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_sel_q      <= wr_sel_d;
      wr_data_q     <= wr_data_d;
      mult_start_q  <= mult_start_d;
      frame_count_q <= frame_count_d;
      err_rdy_q     <= err_rdy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_sel      = wr_sel_q;
  assign wr_data     = wr_data_q;
  assign mult_start  = mult_start_q;
  assign frame_count = frame_count_q;
  assign err_rdy     = err_rdy_q;

endmodule
